// File: rtl/music_pkg.sv
// Shared definitions for the music capture/monitor path.
//   PRESET_W : width of a clock-divider preset
//   TIMEOUT  : default cycles without an edge before a tone is declared absent
//   state_t  : tone_period_meter state encoding
package music_pkg;

    localparam int unsigned PRESET_W = 11;
    localparam int unsigned TIMEOUT  = 4096;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizer plus any-edge detector for an asynchronous square wave.
//   clk       : system clock
//   rst_n     : synchronous active-low reset
//   din       : asynchronous input
//   tone_edge : registered one-cycle pulse on every rising or falling edge
//               of the synchronized input
module sync_edge_det #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic tone_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            prev_q    <= 1'b0;
            tone_edge <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q    <= sync_q[SYNC_STAGES-1];
            tone_edge <= sync_q[SYNC_STAGES-1] ^ prev_q;
        end
    end

endmodule

// File: rtl/tone_period_meter.sv
// Measures the half-period of a square-wave tone in clk cycles and recovers
// the divider preset P (half-period = P+1 cycles).
//   clk          : system clock
//   rst_n        : synchronous active-low reset
//   tone_in      : square wave to measure, may be asynchronous
//   preset_out   : recovered preset while locked, 0 otherwise
//   preset_valid : one-cycle pulse on each accepted measurement while locked
//   tone_present : high while locked
//   range_err    : one-cycle pulse when a half-period exceeds 2^PRESET_W cycles
module tone_period_meter #(
    parameter int unsigned PRESET_W    = music_pkg::PRESET_W,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_COUNT  = 2,
    parameter int unsigned TIMEOUT     = music_pkg::TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tone_in,
    output logic [PRESET_W-1:0] preset_out,
    output logic                preset_valid,
    output logic                tone_present,
    output logic                range_err
);

    import music_pkg::*;

    localparam int unsigned CNT_W   = $clog2(TIMEOUT);
    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0]   CNT_MAX_IN = CNT_W'((1 << PRESET_W) - 1);
    localparam logic [CNT_W-1:0]   CNT_TO     = CNT_W'(TIMEOUT - 1);
    localparam logic [MATCH_W-1:0] MATCH_LOCK = MATCH_W'(LOCK_COUNT);
    localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);

    logic                tone_edge;
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [PRESET_W-1:0] cand_q, cand_d;
    logic [MATCH_W-1:0]  match_q, match_d;
    logic [PRESET_W-1:0] preset_q, preset_d;
    logic                present_q, present_d;
    logic                valid_q, valid_d;
    logic                rerr_q, rerr_d;
    logic                in_range;
    logic                same_as_cand;
    logic                same_as_preset;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (tone_in),
        .tone_edge(tone_edge)
    );

    assign in_range       = (cnt_q <= CNT_MAX_IN);
    assign same_as_cand   = (cnt_q == CNT_W'(cand_q));
    assign same_as_preset = (cnt_q == CNT_W'(preset_q));

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        match_d   = match_q;
        preset_d  = preset_q;
        present_d = present_q;
        valid_d   = 1'b0;
        rerr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (tone_edge) begin
                    state_d = MEASURE;
                    match_d = '0;
                end
            end

            MEASURE: begin
                if (tone_edge) begin
                    if (in_range) begin
                        if (match_q != '0 && same_as_cand) begin
                            match_d = match_q + MATCH_ONE;
                        end else begin
                            cand_d  = cnt_q[PRESET_W-1:0];
                            match_d = MATCH_ONE;
                        end
                        if (match_d >= MATCH_LOCK) begin
                            state_d   = LOCKED;
                            preset_d  = cand_d;
                            present_d = 1'b1;
                            valid_d   = 1'b1;
                        end
                    end else begin
                        rerr_d  = 1'b1;
                        match_d = '0;
                    end
                end else if (cnt_q == CNT_TO) begin
                    state_d   = IDLE;
                    match_d   = '0;
                    preset_d  = '0;
                    present_d = 1'b0;
                end
            end

            LOCKED: begin
                if (tone_edge) begin
                    if (in_range && same_as_preset) begin
                        valid_d = 1'b1;
                    end else if (in_range) begin
                        state_d   = MEASURE;
                        cand_d    = cnt_q[PRESET_W-1:0];
                        match_d   = MATCH_ONE;
                        preset_d  = '0;
                        present_d = 1'b0;
                    end else begin
                        state_d   = MEASURE;
                        rerr_d    = 1'b1;
                        match_d   = '0;
                        preset_d  = '0;
                        present_d = 1'b0;
                    end
                end else if (cnt_q == CNT_TO) begin
                    state_d   = IDLE;
                    match_d   = '0;
                    preset_d  = '0;
                    present_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            match_q   <= '0;
            preset_q  <= '0;
            present_q <= 1'b0;
            valid_q   <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            match_q   <= match_d;
            preset_q  <= preset_d;
            present_q <= present_d;
            valid_q   <= valid_d;
            rerr_q    <= rerr_d;
            // Clearing on entry to IDLE keeps cnt from wrapping past the
            // timeout value on the cycle the timeout fires.
            if (tone_edge || state_d == IDLE) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign preset_out   = preset_q;
    assign preset_valid = valid_q;
    assign tone_present = present_q;
    assign range_err    = rerr_q;

endmodule
